// File: rtl/pattern_deser.sv
// ---------------------------------------------------------------------------
// pattern_deser
//   Serial-to-parallel front end for the second-"01" pattern detector.
//   Assembles a serial bitstream into WIDTH-bit words, queues completed words
//   in a DEPTH-entry FIFO, and presents the head word on a valid/ready port.
//   A sticky overflow flag and a 16-bit accepted-word counter aid debug.
//
// Parameters
//   WIDTH      word width in bits (>= 2)
//   DEPTH      FIFO entries (power of two, >= 2)
//   MSB_FIRST  1: first received bit lands in data_o[WIDTH-1]
//              0: first received bit lands in data_o[0]
//
// Ports
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-high reset
//   bit_i       serial data bit
//   bit_vld_i   bit_i is sampled on this edge
//   flush_i     discard the partially assembled word (wins over bit_vld_i)
//   data_o      FIFO head word (registered)
//   vld_o       FIFO not empty
//   rdy_i       consumer accepts data_o this cycle
//   ovf_o       sticky: a completed word was dropped on a full FIFO
//   clr_ovf_i   clears ovf_o (a same-cycle overflow wins)
//   word_cnt_o  count of words written into the FIFO, wraps silently
// ---------------------------------------------------------------------------
module pattern_deser #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DEPTH     = 2,
   parameter int unsigned MSB_FIRST = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             bit_i,
   input  logic             bit_vld_i,
   input  logic             flush_i,
   output logic [WIDTH-1:0] data_o,
   output logic             vld_o,
   input  logic             rdy_i,
   output logic             ovf_o,
   input  logic             clr_ovf_i,
   output logic [15:0]      word_cnt_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned BW = $clog2(WIDTH);
   localparam int unsigned CW = AW + 1;

   // ------------------------------------------------------------------
   // Deserializer
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] sr_shift;
   logic [BW-1:0]    bcnt;
   logic             word_done;

   if (MSB_FIRST != 0) begin : g_msb_first
      assign sr_shift = {sr[WIDTH-2:0], bit_i};
   end else begin : g_lsb_first
      assign sr_shift = {bit_i, sr[WIDTH-1:1]};
   end

   assign word_done = bit_vld_i & ~flush_i & (bcnt == BW'(WIDTH - 1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sr   <= '0;
         bcnt <= '0;
      end else if (flush_i) begin
         sr   <= '0;
         bcnt <= '0;
      end else if (bit_vld_i) begin
         sr <= sr_shift;
         if (bcnt == BW'(WIDTH - 1)) begin
            bcnt <= '0;
         end else begin
            bcnt <= bcnt + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Output FIFO
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_ptr_inc;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;
   logic             full;
   logic             pop;
   logic             push;
   logic             drop;
   logic             ovf_q;
   logic [15:0]      wcnt_q;

   assign full       = (count == CW'(DEPTH));
   assign pop        = vld_o & rdy_i;
   // A pop on a full FIFO frees a slot in the same edge, so the push fits.
   assign push       = word_done & (~full | pop);
   assign drop       = word_done & full & ~pop;
   assign rd_ptr_inc = rd_ptr + 1'b1;

   // data_o is a register holding the head entry. After a pop the next head
   // is either the following stored entry or, when the FIFO would otherwise
   // run dry, the word being pushed on this same edge.
   always_comb begin
      data_d = data_q;
      if (pop) begin
         if (count > CW'(1)) begin
            data_d = mem[rd_ptr_inc];
         end else if (push) begin
            data_d = sr_shift;
         end
      end else if ((count == '0) && push) begin
         data_d = sr_shift;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= sr_shift;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         data_q <= '0;
      end else begin
         data_q <= data_d;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr_inc;
         end
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Debug: sticky overflow and accepted-word counter
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ovf_q <= 1'b0;
      end else if (drop) begin
         ovf_q <= 1'b1;
      end else if (clr_ovf_i) begin
         ovf_q <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wcnt_q <= '0;
      end else if (push) begin
         wcnt_q <= wcnt_q + 1'b1;
      end
   end

   assign data_o     = data_q;
   assign vld_o      = (count != '0);
   assign ovf_o      = ovf_q;
   assign word_cnt_o = wcnt_q;

endmodule

// File: tb/tb_pattern_deser.sv
// ---------------------------------------------------------------------------
// tb_pattern_deser
//   Directed self-checking bench for pattern_deser. Two instances share all
//   inputs: dut_m (MSB first) and dut_l (LSB first). Inputs change on the
//   falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_pattern_deser;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        bit_i = 1'b0;
   logic        bit_vld = 1'b0;
   logic        flush = 1'b0;
   logic        rdy = 1'b0;
   logic        clr_ovf = 1'b0;

   logic [7:0]  data_m, data_l;
   logic        vld_m, vld_l;
   logic        ovf_m, ovf_l;
   logic [15:0] cnt_m, cnt_l;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   pattern_deser #(.WIDTH(8), .DEPTH(2), .MSB_FIRST(1)) dut_m (
      .clk_i(clk), .rst_i(rst), .bit_i(bit_i), .bit_vld_i(bit_vld),
      .flush_i(flush), .data_o(data_m), .vld_o(vld_m), .rdy_i(rdy),
      .ovf_o(ovf_m), .clr_ovf_i(clr_ovf), .word_cnt_o(cnt_m)
   );

   pattern_deser #(.WIDTH(8), .DEPTH(2), .MSB_FIRST(0)) dut_l (
      .clk_i(clk), .rst_i(rst), .bit_i(bit_i), .bit_vld_i(bit_vld),
      .flush_i(flush), .data_o(data_l), .vld_o(vld_l), .rdy_i(rdy),
      .ovf_o(ovf_l), .clr_ovf_i(clr_ovf), .word_cnt_o(cnt_l)
   );

   task automatic drive(input logic v, input logic b, input logic f);
      @(negedge clk);
      bit_vld = v;
      bit_i   = b;
      flush   = f;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic send_word(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) drive(1'b1, w[i], 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; bit_vld = 1'b0; bit_i = 1'b0; flush = 1'b0;
      rdy = 1'b0; clr_ovf = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++; if (vld_m !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %b expected 0", vld_m); end
      n_cmp++; if (data_m !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h expected 00", data_m); end
      n_cmp++; if (ovf_m !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", ovf_m); end
      n_cmp++; if (cnt_m !== 16'h0000) begin n_err++; $display("FAIL reset_cnt: got %h expected 0000", cnt_m); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_bit_order();
      logic [7:0] pat;
      do_reset();
      rdy = 1'b1;
      pat = 8'b1001_0101;
      send_word(pat);
      n_cmp++; if (vld_m !== 1'b0) begin n_err++; $display("FAIL order_early_vld: got %b expected 0", vld_m); end
      idle();
      n_cmp++; if (vld_m !== 1'b1) begin n_err++; $display("FAIL order_vld: got %b expected 1", vld_m); end
      n_cmp++; if (data_m !== 8'h95) begin n_err++; $display("FAIL order_msb_data: got %h expected 95", data_m); end
      n_cmp++; if (data_l !== 8'hA9) begin n_err++; $display("FAIL order_lsb_data: got %h expected a9", data_l); end
      n_cmp++; if (cnt_m !== 16'd1) begin n_err++; $display("FAIL order_cnt: got %0d expected 1", cnt_m); end
      n_cmp++; if (cnt_l !== 16'd1) begin n_err++; $display("FAIL order_cnt_l: got %0d expected 1", cnt_l); end
      idle();
      n_cmp++; if (vld_m !== 1'b0) begin n_err++; $display("FAIL order_drained: got %b expected 0", vld_m); end
   endtask

   task automatic test_overflow();
      logic [7:0] w;
      do_reset();
      rdy = 1'b0;
      send_word(8'h11);
      send_word(8'h22);
      send_word(8'h33);
      idle();
      n_cmp++; if (ovf_m !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b expected 1", ovf_m); end
      n_cmp++; if (cnt_m !== 16'd2) begin n_err++; $display("FAIL ovf_cnt: got %0d expected 2", cnt_m); end
      n_cmp++; if (data_m !== 8'h11) begin n_err++; $display("FAIL ovf_head: got %h expected 11", data_m); end
      // overflow coinciding with clear: set must win
      w = 8'h55;
      for (int i = 7; i >= 1; i--) drive(1'b1, w[i], 1'b0);
      drive(1'b1, w[0], 1'b0);
      clr_ovf = 1'b1;
      idle();
      clr_ovf = 1'b0;
      n_cmp++; if (ovf_m !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins: got %b expected 1", ovf_m); end
      n_cmp++; if (cnt_m !== 16'd2) begin n_err++; $display("FAIL ovf_cnt2: got %0d expected 2", cnt_m); end
      @(negedge clk);
      n_cmp++; if (data_m !== 8'h11) begin n_err++; $display("FAIL ovf_stable: got %h expected 11", data_m); end
      rdy = 1'b1;
      @(negedge clk);
      n_cmp++; if (data_m !== 8'h22 || vld_m !== 1'b1) begin n_err++; $display("FAIL ovf_second: got %h/%b expected 22/1", data_m, vld_m); end
      @(negedge clk);
      n_cmp++; if (vld_m !== 1'b0) begin n_err++; $display("FAIL ovf_empty: got %b expected 0", vld_m); end
      n_cmp++; if (ovf_m !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b expected 1", ovf_m); end
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      n_cmp++; if (ovf_m !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b expected 0", ovf_m); end
   endtask

   task automatic test_full_push_pop();
      logic [7:0] w;
      do_reset();
      rdy = 1'b0;
      send_word(8'h11);
      send_word(8'h22);
      w = 8'h44;
      for (int i = 7; i >= 1; i--) drive(1'b1, w[i], 1'b0);
      drive(1'b1, w[0], 1'b0);
      rdy = 1'b1;
      idle();
      n_cmp++; if (data_m !== 8'h22 || vld_m !== 1'b1) begin n_err++; $display("FAIL fpp_first: got %h/%b expected 22/1", data_m, vld_m); end
      n_cmp++; if (ovf_m !== 1'b0) begin n_err++; $display("FAIL fpp_ovf: got %b expected 0", ovf_m); end
      n_cmp++; if (cnt_m !== 16'd3) begin n_err++; $display("FAIL fpp_cnt: got %0d expected 3", cnt_m); end
      @(negedge clk);
      n_cmp++; if (data_m !== 8'h44 || vld_m !== 1'b1) begin n_err++; $display("FAIL fpp_second: got %h/%b expected 44/1", data_m, vld_m); end
      @(negedge clk);
      n_cmp++; if (vld_m !== 1'b0) begin n_err++; $display("FAIL fpp_empty: got %b expected 0", vld_m); end
   endtask

   task automatic test_flush();
      do_reset();
      rdy = 1'b1;
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b1);
      send_word(8'h0F);
      idle();
      n_cmp++; if (data_m !== 8'h0F || vld_m !== 1'b1) begin n_err++; $display("FAIL flush_data: got %h/%b expected 0f/1", data_m, vld_m); end
      n_cmp++; if (cnt_m !== 16'd1) begin n_err++; $display("FAIL flush_cnt: got %0d expected 1", cnt_m); end
      idle();
      n_cmp++; if (vld_m !== 1'b0) begin n_err++; $display("FAIL flush_single: got %b expected 0", vld_m); end
   endtask

   task automatic test_async_reset();
      do_reset();
      rdy = 1'b0;
      send_word(8'hA5);
      send_word(8'hB6);
      send_word(8'hC7);
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0);
      idle();
      n_cmp++; if (ovf_m !== 1'b1 || vld_m !== 1'b1) begin n_err++; $display("FAIL arst_pre: got ovf %b vld %b expected 1/1", ovf_m, vld_m); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (vld_m !== 1'b0) begin n_err++; $display("FAIL arst_vld: got %b expected 0", vld_m); end
      n_cmp++; if (ovf_m !== 1'b0) begin n_err++; $display("FAIL arst_ovf: got %b expected 0", ovf_m); end
      n_cmp++; if (cnt_m !== 16'd0) begin n_err++; $display("FAIL arst_cnt: got %0d expected 0", cnt_m); end
      n_cmp++; if (data_m !== 8'h00) begin n_err++; $display("FAIL arst_data: got %h expected 00", data_m); end
      @(negedge clk);
      rst = 1'b0;
      rdy = 1'b1;
      send_word(8'hC3);
      idle();
      n_cmp++; if (data_m !== 8'hC3 || vld_m !== 1'b1) begin n_err++; $display("FAIL arst_after: got %h/%b expected c3/1", data_m, vld_m); end
      n_cmp++; if (cnt_m !== 16'd1) begin n_err++; $display("FAIL arst_cnt_after: got %0d expected 1", cnt_m); end
   endtask

   initial begin
      test_reset();
      test_bit_order();
      test_overflow();
      test_full_push_pop();
      test_flush();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
